// File: rtl/frame_update_arbiter_pkg.sv
// Shared definitions for the frame-synchronous display path: FSM state encoding,
// the displayed-number width and the default vertical timing landmarks.
package frame_update_arbiter_pkg;

    localparam int         FUA_NUM_W = 33;
    localparam logic [9:0] FUA_VBP   = 10'd31;
    localparam logic [9:0] FUA_VFP   = 10'd511;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_COMMIT = 2'd1,
        ST_BLANK  = 2'd2
    } frame_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // B wins when it is the only one pending, or when both pend and A went last.
    function automatic logic pick_b(input logic pend_a, input logic pend_b,
                                    input logic last_src);
        return pend_b & (~pend_a | (last_src == SRC_A));
    endfunction

endpackage

// File: rtl/vblank_edge_detect.sv
// Turns the level "vc is on the first blanking line" into a one-cycle pulse on
// its rising edge. The compare register resets high so a reset released on that line never fires.
module vblank_edge_detect
    import frame_update_arbiter_pkg::*;
#(
    parameter logic [9:0] VFP = FUA_VFP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] vc,
    output logic       pulse
);

    logic at_vfp;
    logic at_vfp_q;

    assign at_vfp = (vc == VFP);
    assign pulse  = at_vfp & ~at_vfp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_vfp_q <= 1'b1;
        end else begin
            at_vfp_q <= at_vfp;
        end
    end

endmodule

// File: rtl/frame_update_arbiter.sv
// Collects display updates from the entry and result paths into one-entry slots and
// commits at most one of them to the displayed number per frame, during vertical blank.
module frame_update_arbiter
    import frame_update_arbiter_pkg::*;
#(
    parameter logic [9:0] VBP   = FUA_VBP,
    parameter logic [9:0] VFP   = FUA_VFP,
    parameter int         NUM_W = FUA_NUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       vc,
    input  logic             a_valid,
    input  logic [NUM_W-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [NUM_W-1:0] b_data,
    output logic             b_ready,
    output logic [NUM_W-1:0] number,
    output logic             frame_tick,
    output logic             last_src,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a clock edge where x_valid and x_ready are
    // both high; x_data is sampled only then, and x_valid is ignored while x_ready is low.

    frame_state_e     state;
    logic             vfp_rise;
    logic             pend_a;
    logic             pend_b;
    logic [NUM_W-1:0] data_a;
    logic [NUM_W-1:0] data_b;
    logic             commit_now;
    logic             win_a;
    logic             win_b;

    vblank_edge_detect #(
        .VFP (VFP)
    ) u_vblank_edge_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .vc    (vc),
        .pulse (vfp_rise)
    );

    assign a_ready    = ~pend_a;
    assign b_ready    = ~pend_b;
    assign dbg_state  = state;
    assign commit_now = (state == ST_COMMIT);
    assign win_b      = pick_b(pend_a, pend_b, last_src);
    assign win_a      = pend_a & ~win_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACTIVE;
            frame_tick <= 1'b0;
            number     <= '0;
            last_src   <= SRC_B;
        end else begin
            frame_tick <= 1'b0;
            unique case (state)
                ST_ACTIVE: begin
                    if (vfp_rise) begin
                        state      <= ST_COMMIT;
                        frame_tick <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_BLANK;
                    if (win_b) begin
                        number   <= data_b;
                        last_src <= SRC_B;
                    end else if (win_a) begin
                        number   <= data_a;
                        last_src <= SRC_A;
                    end
                end
                ST_BLANK: begin
                    if (vc == VBP) begin
                        state <= ST_ACTIVE;
                    end
                end
                default: begin
                    state <= ST_ACTIVE;
                end
            endcase
        end
    end

    // A slot can only be captured while empty, and only cleared while full,
    // so capture and clear never collide in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a <= 1'b0;
            data_a <= '0;
        end else if (a_valid && !pend_a) begin
            pend_a <= 1'b1;
            data_a <= a_data;
        end else if (commit_now && win_a) begin
            pend_a <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_b <= 1'b0;
            data_b <= '0;
        end else if (b_valid && !pend_b) begin
            pend_b <= 1'b1;
            data_b <= b_data;
        end else if (commit_now && win_b) begin
            pend_b <= 1'b0;
        end
    end

endmodule

// File: doc/frame_update_arbiter.md
FRAME_UPDATE_ARBITER -- requirements
Module: frame_update_arbiter

Interface
REQ-001 The block SHALL have parameter VBP, default 10'd31, giving the first active-video line value of vc.
REQ-002 The block SHALL have parameter VFP, default 10'd511, giving the first vertical-blank line value of vc.
REQ-003 The block SHALL have parameter NUM_W, default 33, giving the width of the displayed number.
REQ-004 clk  in  1  master clock, 50 MHz, rising-edge; one clock; reset is asynchronous and active-low.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 vc  in  10  vertical line counter from the vga640x480 timing block.
REQ-007 a_valid  in  1  entry-path request: operand being typed.
REQ-008 a_data  in  NUM_W  entry-path value.
REQ-009 a_ready  out  1  entry-path slot free.
REQ-010 b_valid  in  1  result-path request: ALU result.
REQ-011 b_data  in  NUM_W  result-path value.
REQ-012 b_ready  out  1  result-path slot free.
REQ-013 number  out  NUM_W  value shown by background_painter; stable throughout active video.
REQ-014 frame_tick  out  1  one-cycle pulse in the commit cycle.
REQ-015 last_src  out  1  source of the last committed value: 0 = A, 1 = B.

Function
REQ-016 Each source SHALL have a one-entry holding slot (pend_x, data_x); x_ready SHALL equal ~pend_x.
REQ-017 On x_valid & x_ready at a clock edge, data_x SHALL capture x_data and pend_x SHALL set; x_data is sampled only in that cycle.
REQ-018 While pend_x is set, x_valid SHALL be ignored and data_x SHALL hold.
REQ-019 FSM states SHALL be ACTIVE, COMMIT and BLANK.
REQ-020 ACTIVE -> COMMIT SHALL occur only on the rising edge of (vc == VFP), detected against a registered copy of that compare.
REQ-021 COMMIT SHALL last exactly one cycle, then go to BLANK.
REQ-022 BLANK -> ACTIVE SHALL occur when vc == VBP; all other cases SHALL hold state.
REQ-023 In COMMIT, frame_tick SHALL be 1; in all other states it SHALL be 0.
REQ-024 Commit arbitration when only one slot is pending: that slot SHALL win.
REQ-025 Commit arbitration when both slots are pending: the source opposite to last_src SHALL win (round-robin).
REQ-026 Commit arbitration when no slot is pending: number and last_src SHALL be unchanged.
REQ-027 The winner's data SHALL load into number at the edge ending COMMIT; the winner's pend SHALL clear and last_src SHALL update at the same edge.
REQ-028 The losing slot SHALL stay pending for the next frame.
REQ-029 Latency SHALL be: number changes exactly 1 cycle after frame_tick rises; at most one commit occurs per frame.
REQ-030 A request accepted in the COMMIT cycle itself SHALL NOT be eligible that frame.
REQ-031 A slot cleared in COMMIT SHALL show ready = 1 in the first BLANK cycle.
REQ-032 number SHALL never change outside the COMMIT edge.
REQ-033 If vc skips VFP (resync), no commit SHALL occur that frame and pending data SHALL be retained.
REQ-034 If vc == VFP is already true when rst_n deasserts, no commit SHALL occur until the next rising edge of the compare.

Reset
REQ-035 While rst_n = 0, asynchronously: state = ACTIVE, pend_a = pend_b = 0, number = 0, last_src = 1, frame_tick = 0, and the VFP-compare register = 1.
REQ-036 During reset, a_ready and b_ready SHALL read 1 and no request SHALL be accepted.
REQ-037 Reset asserted mid-frame SHALL discard pending data; the displayed value then returns to 0.

Structure
REQ-038 A shared package SHALL hold the state enum, NUM_W, and the VBP/VFP defaults, for reuse by vga640x480 and painter_chooser.
REQ-039 One sub-module, vblank_edge_detect (vc compare plus registered edge to a one-cycle pulse), SHALL be instantiated; the arbiter and FSM SHALL stay in the top.

Verification
REQ-040 Bench: reset, then a_valid with a_data = 33'd10 during line 100 -> a_ready = 0 next cycle, number = 0 until frame_tick, number = 10 one cycle after it, last_src = 0.
REQ-041 Bench: both valid in one cycle during active video (A = 5, B = 7), last_src = 1 -> frame 1 commits 5; frame 2 commits 7; b_ready stays 0 through frame 1.
REQ-042 Bench: hold vc = 511 for 800 clocks -> exactly one frame_tick pulse; no second commit.
REQ-043 Bench: b_valid asserted in the COMMIT cycle with no slot pending -> number unchanged this frame; 33'h1_0000_0001 is committed the next frame.
REQ-044 Bench: assert rst_n = 0 while pend_a = 1 in BLANK -> number = 0, a_ready = 1 immediately; after release, no commit until vc next transitions to 511.
REQ-045 Bench: vc jumps 400 -> 0, skipping 511, with B pending -> no frame_tick; B is committed at the following true vblank.
